// File: rtl/spi_master_multi_cs.sv
// SPI master: programmable SCK divider, CPOL/CPHA modes, MSB/LSB-first order,
// multiple chip selects, runtime transfer length with right-aligned read data.
module spi_master_multi_cs #(
   parameter int DATA_WIDTH      = 70,
   parameter int BIT_COUNT_WIDTH = 8,
   parameter int NUM_CS          = 4,
   parameter int CS_SEL_WIDTH    = 2,
   parameter int DIV_WIDTH       = 8
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       START,
   output logic                       BUSY,
   output logic                       DONE,
   input  logic [BIT_COUNT_WIDTH-1:0] NUM_OF_BIT,
   input  logic [DIV_WIDTH-1:0]       CLK_DIV,
   input  logic                       CPOL,
   input  logic                       CPHA,
   input  logic                       LSB_FIRST,
   input  logic [CS_SEL_WIDTH-1:0]    CS_SEL,
   input  logic [DATA_WIDTH-1:0]      DATA_IN,
   output logic [DATA_WIDTH-1:0]      RD_DATA,
   output logic [NUM_CS-1:0]          SPI_CS_N,
   output logic                       SPI_SCK,
   output logic                       SPI_SDO,
   input  logic                       SPI_SDI
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LEAD, SHIFT_TRAIL, HOLD, ALIGN, DONE_ST} state_t;

   localparam logic [BIT_COUNT_WIDTH-1:0] DW_B   = BIT_COUNT_WIDTH'(DATA_WIDTH);
   localparam logic [BIT_COUNT_WIDTH-1:0] DW_M1  = BIT_COUNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [BIT_COUNT_WIDTH-1:0] BC_ONE = BIT_COUNT_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0]       DV_ONE = DIV_WIDTH'(1);

   state_t                      state, next_state;
   logic [BIT_COUNT_WIDTH-1:0]  n_q, n_eff, bit_cnt;
   logic [DIV_WIDTH-1:0]        div_q, div_cnt;
   logic                        cpol_q, cpha_q, lsb_q;
   logic [CS_SEL_WIDTH-1:0]     cs_q, cs_nxt;
   logic [DATA_WIDTH-1:0]       tx, rx, tx_init, tx_shift, rx_shift;
   logic                        accept, div_zero, cs_act, tx_head, init_head;
   logic                        enter_lead, enter_trail;

   always_comb begin
      n_eff     = (NUM_OF_BIT > DW_B) ? DW_B : NUM_OF_BIT;
      accept    = (state == IDLE) && START && !BUSY;
      div_zero  = (div_cnt == '0);
      // MSB-first words are pre-shifted so the first bit always sits at the top
      tx_init   = LSB_FIRST ? DATA_IN : (DATA_IN << (DW_B - n_eff));
      init_head = LSB_FIRST ? tx_init[0] : tx_init[DATA_WIDTH-1];
      tx_head   = lsb_q ? tx[0] : tx[DATA_WIDTH-1];
      tx_shift  = lsb_q ? (tx >> 1) : (tx << 1);
      rx_shift  = lsb_q ? {SPI_SDI, rx[DATA_WIDTH-1:1]} : {rx[DATA_WIDTH-2:0], SPI_SDI};
      cs_nxt    = accept ? CS_SEL : cs_q;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:        if (accept) next_state = (n_eff == '0) ? DONE_ST : SETUP;
         SETUP:       if (div_zero) next_state = SHIFT_LEAD;
         SHIFT_LEAD:  if (div_zero) next_state = SHIFT_TRAIL;
         SHIFT_TRAIL: if (div_zero) next_state = (bit_cnt == n_q) ? HOLD : SHIFT_LEAD;
         HOLD:        if (div_zero) next_state = (lsb_q && n_q != DW_B) ? ALIGN : DONE_ST;
         ALIGN:       if (bit_cnt == DW_M1) next_state = DONE_ST;
         DONE_ST:     next_state = IDLE;
         default:     next_state = IDLE;
      endcase
   end

   always_comb begin
      cs_act      = (next_state == SETUP) || (next_state == SHIFT_LEAD) ||
                    (next_state == SHIFT_TRAIL) || (next_state == HOLD);
      enter_lead  = (next_state == SHIFT_LEAD) && (state != SHIFT_LEAD);
      enter_trail = (next_state == SHIFT_TRAIL) && (state != SHIFT_TRAIL);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         RD_DATA  <= '0;
         SPI_CS_N <= '1;
         SPI_SCK  <= 1'b0;
         SPI_SDO  <= 1'b0;
         n_q      <= '0;
         bit_cnt  <= '0;
         div_q    <= '0;
         div_cnt  <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         cs_q     <= '0;
         tx       <= '0;
         rx       <= '0;
      end else begin
         BUSY <= (state != IDLE);
         DONE <= (state == DONE_ST);
         for (int i = 0; i < NUM_CS; i++)
            SPI_CS_N[i] <= !(cs_act && (int'(cs_nxt) == i));

         // every phase change reloads the half-period counter
         if (next_state != state) div_cnt <= accept ? CLK_DIV : div_q;
         else if (!div_zero)      div_cnt <= div_cnt - DV_ONE;

         case (state)
            IDLE: begin
               SPI_SCK <= CPOL;
               if (accept) begin
                  n_q     <= n_eff;
                  div_q   <= CLK_DIV;
                  cpol_q  <= CPOL;
                  cpha_q  <= CPHA;
                  lsb_q   <= LSB_FIRST;
                  cs_q    <= CS_SEL;
                  rx      <= '0;
                  bit_cnt <= '0;
                  if (!CPHA && n_eff != '0) begin
                     SPI_SDO <= init_head;
                     tx      <= LSB_FIRST ? (tx_init >> 1) : (tx_init << 1);
                  end else begin
                     tx      <= tx_init;
                  end
               end
            end
            ALIGN: begin
               rx      <= rx >> 1;
               bit_cnt <= bit_cnt + BC_ONE;
            end
            DONE_ST: RD_DATA <= rx;
            default: ;
         endcase

         if (enter_lead) begin
            SPI_SCK <= !cpol_q;
            if (!cpha_q) rx <= rx_shift;
            else begin
               SPI_SDO <= tx_head;
               tx      <= tx_shift;
            end
         end

         if (enter_trail) begin
            SPI_SCK <= cpol_q;
            bit_cnt <= bit_cnt + BC_ONE;
            if (cpha_q) rx <= rx_shift;
            else if (bit_cnt + BC_ONE < n_q) begin
               SPI_SDO <= tx_head;
               tx      <= tx_shift;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master_multi_cs.sv
// Scoreboard bench for spi_master_multi_cs: stimulus pushes expected transfer
// results, a negedge monitor accumulates bus activity and checks on each DONE.
module tb_spi_master_multi_cs;

   localparam int DW = 70;

   logic          CLK, RESET, START, BUSY, DONE, CPOL, CPHA, LSB_FIRST;
   logic [7:0]    NUM_OF_BIT, CLK_DIV;
   logic [1:0]    CS_SEL;
   logic [DW-1:0] DATA_IN, RD_DATA;
   logic [3:0]    SPI_CS_N;
   logic          SPI_SCK, SPI_SDO, SPI_SDI;
   logic          tie1;

   assign SPI_SDI = tie1 ? 1'b1 : SPI_SDO;

   spi_master_multi_cs dut (
      .CLK(CLK), .RESET(RESET), .START(START), .BUSY(BUSY), .DONE(DONE),
      .NUM_OF_BIT(NUM_OF_BIT), .CLK_DIV(CLK_DIV), .CPOL(CPOL), .CPHA(CPHA),
      .LSB_FIRST(LSB_FIRST), .CS_SEL(CS_SEL), .DATA_IN(DATA_IN), .RD_DATA(RD_DATA),
      .SPI_CS_N(SPI_CS_N), .SPI_SCK(SPI_SCK), .SPI_SDO(SPI_SDO), .SPI_SDI(SPI_SDI)
   );

   typedef struct {
      logic [DW-1:0] rd, seq;
      int            n, cs_low, mask, tog, gap, start_cyc;
      bit            from_start;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0, n_err = 0, cyc = 0;

   // monitor accumulators, owned by the monitor process
   int            cs_low, cs_rise, sck_tog, sck_rise, unstable;
   logic [3:0]    cs_seen, cs_prev;
   logic [DW-1:0] seq;
   logic          sck_prev, sdo_prev;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] msk(input int n);
      msk = '0;
      for (int i = 0; i < n; i++) msk[i] = 1'b1;
   endfunction

   function automatic logic [DW-1:0] rev(input logic [DW-1:0] d, input int n);
      rev = '0;
      for (int i = 0; i < n; i++) rev[n-1-i] = d[i];
   endfunction

   always @(negedge CLK) begin
      if (RESET) begin
         cs_low = 0; sck_tog = 0; sck_rise = 0; unstable = 0;
         cs_seen = '0; seq = '0; cs_rise = cyc;
      end else begin
         if (SPI_CS_N != 4'hF) begin
            cs_low++;
            cs_seen = cs_seen | ~SPI_CS_N;
         end
         if (SPI_CS_N == 4'hF && cs_prev != 4'hF) cs_rise = cyc;
         if (SPI_SCK != sck_prev) sck_tog++;
         if (SPI_SCK && !sck_prev && SPI_CS_N != 4'hF) begin
            sck_rise++;
            seq = {seq[DW-2:0], SPI_SDO};
            if (SPI_SDO != sdo_prev) unstable++;
         end
         if (DONE) begin
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_done: got DONE expected none (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("rd_data", RD_DATA, e.rd);
               chk("cs_low_cycles", DW'(cs_low), DW'(e.cs_low));
               chk("cs_seen", DW'(cs_seen), DW'(e.mask));
               chk("sck_toggles", DW'(sck_tog), DW'(e.tog));
               chk("sck_rises", DW'(sck_rise), DW'(e.n));
               chk("done_gap", DW'(cyc - (e.from_start ? e.start_cyc : cs_rise)), DW'(e.gap));
               if (e.n > 0) begin
                  chk("sdo_seq", seq & msk(e.n), e.seq);
                  chk("sdo_unstable", DW'(unstable), '0);
               end
            end
            cs_low = 0; sck_tog = 0; sck_rise = 0; unstable = 0;
            cs_seen = '0; seq = '0;
         end
      end
      sck_prev = SPI_SCK; sdo_prev = SPI_SDO; cs_prev = SPI_CS_N;
   end

   task automatic setcfg(input int nb, input int div, input logic pol, input logic pha,
                         input logic lsb, input int sel, input logic [DW-1:0] d);
      @(posedge CLK); #1;
      NUM_OF_BIT = 8'(nb); CLK_DIV = 8'(div); CPOL = pol; CPHA = pha;
      LSB_FIRST = lsb; CS_SEL = 2'(sel); DATA_IN = d;
      repeat (3) @(posedge CLK);
      #1;
   endtask

   task automatic push(input int ne, input logic lsb, input logic [DW-1:0] d, input logic [DW-1:0] rd,
                       input int csl, input int mask, input int tog, input int gap, input bit fs);
      exp_t e;
      e.n = ne; e.rd = rd; e.cs_low = csl; e.mask = mask; e.tog = tog; e.gap = gap;
      e.from_start = fs; e.start_cyc = cyc;
      e.seq = lsb ? rev(d, ne) : (d & msk(ne));
      q.push_back(e);
   endtask

   task automatic xfer(input int nb, input int div, input logic pol, input logic pha, input logic lsb,
                       input int sel, input logic [DW-1:0] d, input logic [DW-1:0] rd,
                       input int csl, input int mask, input int tog, input int gap, input bit fs);
      setcfg(nb, div, pol, pha, lsb, sel, d);
      START = 1'b1;
      push((nb > DW) ? DW : nb, lsb, d, rd, csl, mask, tog, gap, fs);
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic drain(input int maxc);
      int c;
      c = 0;
      while (q.size() != 0 && c < maxc) begin
         @(posedge CLK);
         c++;
      end
      if (q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain: got %0d pending transfers expected 0 after %0d cycles", q.size(), maxc);
         q.delete();
      end
      repeat (3) @(posedge CLK);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] alt, big;
      int c;
      alt = {35{2'b01}};
      big = 70'h3_0123_4567_89AB_CDEF;
      RESET = 1'b1; START = 1'b0; NUM_OF_BIT = '0; CLK_DIV = '0; CPOL = 1'b0; CPHA = 1'b0;
      LSB_FIRST = 1'b0; CS_SEL = '0; DATA_IN = '0; tie1 = 1'b0;
      repeat (2) @(posedge CLK); #1;
      chk("rst_busy", DW'(BUSY), '0);
      chk("rst_done", DW'(DONE), '0);
      chk("rst_rd_data", RD_DATA, '0);
      chk("rst_cs_n", DW'(SPI_CS_N), DW'(4'hF));
      chk("rst_sck", DW'(SPI_SCK), '0);
      chk("rst_sdo", DW'(SPI_SDO), '0);
      RESET = 1'b0;

      // mode 0, MSB-first, 0xA5 loopback
      xfer(8, 0, 0, 0, 0, 0, 70'hA5, 70'hA5, 18, 4'b0001, 16, 1, 0);
      drain(200);
      // mode 3, LSB-first, full width, half-period 4; one idle SCK rise from CPOL change
      xfer(70, 3, 1, 1, 1, 2, alt, alt, 568, 4'b0100, 141, 1, 0);
      drain(1000);
      // LSB-first short word with SDI tied high: 58 align cycles before DONE
      tie1 = 1'b1;
      xfer(12, 0, 1, 1, 1, 1, 70'hABC, 70'hFFF, 26, 4'b0010, 24, 59, 0);
      drain(300);
      tie1 = 1'b0;
      // zero-length transfer
      xfer(0, 0, 1, 0, 0, 0, 70'h1234, '0, 0, 4'b0000, 0, 2, 1);
      drain(50);

      // START held high: second acceptance only once back in idle with BUSY low
      setcfg(8, 0, 0, 0, 0, 3, 70'h3C);
      START = 1'b1;
      push(8, 0, 70'h3C, 70'h3C, 18, 4'b1000, 17, 1, 0);
      repeat (5) @(posedge CLK); #1;
      DATA_IN = 70'hC3;
      c = 0;
      do begin @(negedge CLK); c++; end while (!DONE && c < 100);
      if (!DONE) begin
         n_vec++; n_err++;
         $display("FAIL held_start_done: got no DONE expected DONE within 100 cycles");
      end
      push(8, 0, 70'hC3, 70'hC3, 18, 4'b1000, 16, 1, 0);
      @(posedge CLK); @(posedge CLK); #1;
      START = 1'b0;
      repeat (5) @(posedge CLK); #1;
      DATA_IN = '0;
      drain(200);

      // reset during bit 5 of a 16-bit transfer
      xfer(16, 0, 0, 0, 0, 0, 70'hBEEF, 70'hBEEF, 34, 4'b0001, 32, 1, 0);
      void'(q.pop_back());
      repeat (11) @(posedge CLK); #1;
      chk("pre_rst_busy", DW'(BUSY), DW'(1));
      chk("pre_rst_cs_n", DW'(SPI_CS_N), DW'(4'b1110));
      RESET = 1'b1;
      #1;
      chk("mid_rst_cs_n", DW'(SPI_CS_N), DW'(4'hF));
      chk("mid_rst_sck", DW'(SPI_SCK), '0);
      chk("mid_rst_busy", DW'(BUSY), '0);
      chk("mid_rst_done", DW'(DONE), '0);
      repeat (2) @(posedge CLK); #1;
      RESET = 1'b0;
      repeat (20) @(posedge CLK);
      xfer(16, 0, 0, 0, 0, 0, 70'h1234, 70'h1234, 34, 4'b0001, 32, 1, 0);
      drain(200);

      // oversized length clamps to full width
      xfer(200, 0, 0, 0, 0, 0, big, big, 142, 4'b0001, 140, 1, 0);
      drain(400);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_master_multi_cs.md
Name: spi_master_multi_cs

Overview:
Parametrised SPI master for the ultrasound front end. It succeeds the fixed mode-0, LSB-first, CLK/2 transceiver. It adds a programmable SCK divider, all four CPOL/CPHA modes, MSB/LSB-first selection, and N independent chip selects for multiple pulser/AFE devices. Each transfer length is runtime-selectable up to DATA_WIDTH. Received data is returned right-aligned with a START/BUSY/DONE handshake.

Parameters:
DATA_WIDTH, 70, max bits per transfer (shift register width)
BIT_COUNT_WIDTH, 8, width of NUM_OF_BIT; must hold DATA_WIDTH
NUM_CS, 4, number of chip-select outputs
CS_SEL_WIDTH, 2, width of CS_SEL; 2**CS_SEL_WIDTH >= NUM_CS
DIV_WIDTH, 8, width of CLK_DIV

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
START  in  1  start request, sampled only in IDLE
BUSY  out  1  high from the cycle after START acceptance through the DONE cycle
DONE  out  1  one-cycle pulse; RD_DATA valid from this cycle
NUM_OF_BIT  in  BIT_COUNT_WIDTH  bits to shift (N)
CLK_DIV  in  DIV_WIDTH  SCK half-period = CLK_DIV+1 CLK cycles (H)
CPOL  in  1  SCK idle level
CPHA  in  1  0 = sample on leading edge; 1 = sample on trailing edge
LSB_FIRST  in  1  bit order select
CS_SEL  in  CS_SEL_WIDTH  target chip-select index
DATA_IN  in  DATA_WIDTH  TX word, right-aligned in DATA_IN[N-1:0]
RD_DATA  out  DATA_WIDTH  RX word, right-aligned, upper bits zero
SPI_CS_N  out  NUM_CS  active-low chip selects
SPI_SCK  out  1  serial clock
SPI_SDO  out  1  serial data out
SPI_SDI  in  1  serial data in

Behaviour:
- Reset values: BUSY=0, DONE=0, RD_DATA=0, SPI_CS_N=all 1, SPI_SCK=0, SPI_SDO=0. State goes to IDLE.
- Reset mid-transfer aborts immediately with the same values. No DONE is produced.
- Latching on START in IDLE:
  - All config inputs and DATA_IN are latched and held for the whole transfer.
  - Later input changes have no effect.
  - START while BUSY is ignored; it is not queued.
- N clamping:
  - N > DATA_WIDTH is clamped to DATA_WIDTH.
  - N = 0: no CS, no SCK. IDLE -> DONE_ST next cycle. DONE pulses 2 cycles after START; RD_DATA = 0.
- IDLE output levels: SPI_SCK tracks the CPOL input, registered; SPI_SDO holds its last value.
- States: IDLE -> SETUP -> SHIFT_LEAD <-> SHIFT_TRAIL -> HOLD -> ALIGN -> DONE_ST -> IDLE.
- SETUP (H cycles):
  - SPI_CS_N[CS_SEL] = 0; SCK = CPOL.
  - CPHA=0: SDO drives the first bit on CS assertion.
- SHIFT_LEAD / SHIFT_TRAIL (H cycles each, N times):
  - The leading SCK edge enters LEAD; the trailing edge enters TRAIL.
  - CPHA=0: sample SDI at the leading edge; drive the next SDO bit at the trailing edge.
  - CPHA=1: drive SDO at the leading edge; sample SDI at the trailing edge.
  - After the N-th trailing phase, go to HOLD.
- HOLD (H cycles): SCK = CPOL, CS stays low. Total CS-low time is exactly (2N+2)*H cycles. Then CS deasserts.
- Bit order:
  - MSB-first: TX sends DATA_IN[N-1] first. RX shifts left, SDI into bit 0.
  - LSB-first: TX sends DATA_IN[0] first. RX shifts right, SDI into bit DATA_WIDTH-1.
- ALIGN:
  - LSB-first only: DATA_WIDTH-N single-bit right shifts, one per cycle, zero-filling.
  - MSB-first: 0 cycles.
- DONE_ST: RD_DATA <= rx register; DONE=1 and BUSY=1 for this one cycle. Next cycle is IDLE, BUSY=0, DONE=0.
- DONE timing: 1 cycle after CS deassert for MSB-first; 1+(DATA_WIDTH-N) cycles for LSB-first.
- Bit counter: counts shifted bits, compared against latched N; wraps never. The divider counter reloads at every phase change.
- CS_SEL >= NUM_CS: transfer runs normally with all SPI_CS_N high. RD_DATA is still captured.
- Only one CS is ever low at a time. Glitch-free: CS, SCK and SDO are all registered outputs.

Test Plan:
- Mode 0, MSB-first, N=8, CLK_DIV=0, DATA_IN=0xA5, SDO looped to SDI:
  - exactly 8 SCK rising edges with SDO stable across each; SDO bit sequence 1,0,1,0,0,1,0,1;
  - CS_N[0] low 18 cycles; RD_DATA=0x0A5; one DONE pulse.
- Mode 3, LSB-first, N=70, CLK_DIV=3, CS_SEL=2, DATA_IN=alternating 01 pattern, loopback:
  - SCK idles high with half-period 4 cycles; only CS_N[2] toggles;
  - RD_DATA == DATA_IN; DONE 1 cycle after CS rises.
- LSB-first, N=12, SDI tied 1:
  - RD_DATA=0xFFF with upper 58 bits zero;
  - DONE exactly 59 cycles after CS deassert.
- N=0 START:
  - no CS or SCK activity; DONE 2 cycles after START; RD_DATA=0.
- START held high across a transfer, with DATA_IN changed mid-transfer:
  - exactly one transfer per IDLE acceptance; transmitted bits match the latched DATA_IN.
- RESET asserted mid-transfer (bit 5 of 16):
  - same cycle: all CS_N=1, SCK=0, BUSY=0, no DONE;
  - a subsequent transfer completes correctly.
